// File: rtl/root_square.sv
// root_square: sequential radicand reconstructor, d = q*q + r (mod 2^32), via a 16-step LSB-first shift-add.
// Optional macro SQUARE_RANGE_CHECK_EN adds the err output (remainder > 2q, or 32-bit overflow).
module root_square (
    input  logic        clk,
    input  logic        clrn,
    input  logic [15:0] q,
    input  logic [16:0] r,
    input  logic        load,
    output logic [31:0] d,
    output logic        busy,
    output logic        ready,
    output logic [3:0]  count
`ifdef SQUARE_RANGE_CHECK_EN
    ,
    output logic        err
`endif
);

    logic [31:0] reg_a_q, reg_a_d;
    logic [15:0] reg_m_q, reg_m_d;
    logic [32:0] reg_acc_q, reg_acc_d;
    logic [3:0]  count_q, count_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;
    logic [31:0] addend_s;
    logic [32:0] acc_sum_s;
`ifdef SQUARE_RANGE_CHECK_EN
    logic        err_q, err_d;
`endif

    // Next-state logic: load wins over an in-flight iteration; idle holds everything.
    always_comb begin
        reg_a_d   = reg_a_q;
        reg_m_d   = reg_m_q;
        reg_acc_d = reg_acc_q;
        count_d   = count_q;
        busy_d    = busy_q;
        ready_d   = ready_q;
`ifdef SQUARE_RANGE_CHECK_EN
        err_d     = err_q;
`endif
        addend_s  = reg_m_q[0] ? reg_a_q : 32'd0;
        acc_sum_s = reg_acc_q + {1'b0, addend_s};

        if (load) begin
            reg_a_d   = {16'd0, q};
            reg_m_d   = q;
            reg_acc_d = {16'd0, r};
            count_d   = 4'd0;
            busy_d    = 1'b1;
            ready_d   = 1'b0;
`ifdef SQUARE_RANGE_CHECK_EN
            err_d     = (r > {q, 1'b0});
`endif
        end else if (busy_q) begin
            reg_acc_d = acc_sum_s;
            reg_a_d   = {reg_a_q[30:0], 1'b0};
            reg_m_d   = {1'b0, reg_m_q[15:1]};
            count_d   = count_q + 4'd1;
            // The sixteenth step finishes the product; count wraps back to zero naturally.
            if (count_q == 4'hf) begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
`ifdef SQUARE_RANGE_CHECK_EN
                err_d   = err_q | acc_sum_s[32];
`endif
            end else begin
                busy_d  = 1'b1;
                ready_d = 1'b0;
            end
        end else begin
            busy_d  = 1'b0;
            ready_d = ready_q;
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            reg_a_q   <= 32'd0;
            reg_m_q   <= 16'd0;
            reg_acc_q <= 33'd0;
            count_q   <= 4'd0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
`ifdef SQUARE_RANGE_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            reg_a_q   <= reg_a_d;
            reg_m_q   <= reg_m_d;
            reg_acc_q <= reg_acc_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
`ifdef SQUARE_RANGE_CHECK_EN
            err_q     <= err_d;
`endif
        end
    end

    assign d     = reg_acc_q[31:0];
    assign busy  = busy_q;
    assign ready = ready_q;
    assign count = count_q;
`ifdef SQUARE_RANGE_CHECK_EN
    assign err   = err_q;
`endif

endmodule

// File: tb/tb_root_square.sv
// Directed self-checking bench for root_square; err checks are compiled in with SQUARE_RANGE_CHECK_EN.
module tb_root_square;

    logic        clk = 1'b0;
    logic        clrn;
    logic [15:0] q;
    logic [16:0] r;
    logic        load;
    logic [31:0] d;
    logic        busy;
    logic        ready;
    logic [3:0]  count;
`ifdef SQUARE_RANGE_CHECK_EN
    logic        err;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    root_square dut (
        .clk   (clk),
        .clrn  (clrn),
        .q     (q),
        .r     (r),
        .load  (load),
        .d     (d),
        .busy  (busy),
        .ready (ready),
        .count (count)
`ifdef SQUARE_RANGE_CHECK_EN
        ,
        .err   (err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply a one-cycle load pulse; returns at the falling edge after the load edge.
    task automatic start(input logic [15:0] qv, input logic [16:0] rv);
        @(negedge clk);
        q    = qv;
        r    = rv;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Check n busy cycles ({ready,busy,count} = {0,1,i}), stopping with count == n showing.
    task automatic step(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            chk(tag, {26'd0, ready, busy, count}, {26'd0, 1'b0, 1'b1, 4'(i)});
            @(negedge clk);
        end
    endtask

    task automatic run_done(input logic [31:0] exp_d, input string tag);
        step(16, tag);
        chk({tag, "_flags"}, {26'd0, ready, busy, count}, {26'd0, 1'b1, 1'b0, 4'd0});
        chk({tag, "_d"}, d, exp_d);
    endtask

    initial begin
        clrn = 1'b0;
        load = 1'b0;
        q    = 16'd0;
        r    = 17'd0;
        #2;
        chk("reset_flags", {26'd0, ready, busy, count}, 32'd0);
        chk("reset_d", d, 32'd0);
`ifdef SQUARE_RANGE_CHECK_EN
        chk("reset_err", {31'd0, err}, 32'd0);
`endif

        // Release reset and present a load in the same cycle.
        @(negedge clk);
        clrn = 1'b1;
        q    = 16'd3;
        r    = 17'd2;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        run_done(32'h0000000B, "q3r2");
`ifdef SQUARE_RANGE_CHECK_EN
        chk("q3r2_err", {31'd0, err}, 32'd0);
`endif

        start(16'hFFFF, 17'h1FFFE);
        run_done(32'hFFFFFFFF, "max_valid");
`ifdef SQUARE_RANGE_CHECK_EN
        chk("max_valid_err", {31'd0, err}, 32'd0);
`endif
        repeat (3) @(negedge clk);
        chk("hold_ready", {31'd0, ready}, 32'd1);
        chk("hold_d", d, 32'hFFFFFFFF);

        start(16'h8000, 17'd0);
        run_done(32'h40000000, "q8000");
        start(16'h0000, 17'd0);
        chk("reload_ready_drop", {31'd0, ready}, 32'd0);
        run_done(32'h00000000, "q0");

        // Restart mid-operation at count 7.
        start(16'h1234, 17'd0);
        step(7, "pre_reload");
        chk("reload_at7", {28'd0, count}, 32'd7);
        q    = 16'd5;
        r    = 17'd1;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        run_done(32'h0000001A, "reload");

        // Asynchronous abort at count 9.
        start(16'h00FF, 17'h10);
        step(9, "pre_abort");
        chk("abort_at9", {28'd0, count}, 32'd9);
        clrn = 1'b0;
        #1;
        chk("abort_flags", {26'd0, ready, busy, count}, 32'd0);
        chk("abort_d", d, 32'd0);
        @(negedge clk);
        clrn = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_ready", {26'd0, ready, busy, count}, 32'd0);
        chk("abort_d_hold", d, 32'd0);

        // Out-of-range pairs: d wraps mod 2^32 in both builds.
        start(16'd5, 17'd11);
        run_done(32'h00000024, "q5r11");
`ifdef SQUARE_RANGE_CHECK_EN
        chk("q5r11_err", {31'd0, err}, 32'd1);
`endif
        start(16'hFFFF, 17'h1FFFF);
        run_done(32'h00000000, "overflow");
`ifdef SQUARE_RANGE_CHECK_EN
        chk("overflow_err", {31'd0, err}, 32'd1);
        start(16'd2, 17'd4);
        chk("err_clear_on_load", {31'd0, err}, 32'd0);
        run_done(32'h00000008, "q2r4");
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
